// File: rtl/delay_timer_if.sv
// Start/status handshake between a protocol FSM (master) and the delay timer (slave).
interface delay_timer_if;
    logic start;
    logic active;
    logic done;

    modport master (output start, input active, input done);
    modport slave  (input start, output active, output done);
endinterface

// File: rtl/delay_timer.sv
// Single-shot delay timer: a start pulse yields a one-cycle done pulse N_CLKS edges later,
// counting the edge that samples start as edge #1.
module delay_timer #(
    parameter int unsigned N_CLKS = 100
) (
    input  logic          clk,
    input  logic          rst,
    delay_timer_if.slave  bus
);

    localparam int unsigned CW = $clog2(N_CLKS + 1);
    localparam logic [CW-1:0] LAST = CW'(N_CLKS - 1);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t        state;
    logic [CW-1:0] count;

    // The start edge is counted as #1, so COUNT begins at 1; N_CLKS==1 completes
    // at the start edge without ever entering COUNT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            bus.active <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (N_CLKS == 1) begin
                            bus.done <= 1'b1;
                        end else begin
                            state      <= COUNT;
                            count      <= CW'(1);
                            bus.active <= 1'b1;
                        end
                    end
                end
                COUNT: begin
                    if (count == LAST) begin
                        state      <= IDLE;
                        count      <= '0;
                        bus.active <= 1'b0;
                        bus.done   <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    count      <= '0;
                    bus.active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_timer.sv
// Directed bench for delay_timer at N_CLKS = 100, 2 and 1.
module tb_delay_timer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    delay_timer_if if100 ();
    delay_timer_if if2 ();
    delay_timer_if if1 ();

    delay_timer #(.N_CLKS(100)) u100 (.clk(clk), .rst(rst), .bus(if100));
    delay_timer #(.N_CLKS(2))   u2   (.clk(clk), .rst(rst), .bus(if2));
    delay_timer #(.N_CLKS(1))   u1   (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic start;
        logic act2;
        logic done2;
        logic done1;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start on edge #1 plus optional extra pulses at edges a and b during the delay.
    task automatic run_delay(input int a, input int b, input string tag);
        for (int e = 1; e <= 101; e++) begin
            if100.start = (e == 1 || e == a || e == b);
            step();
            chk($sformatf("%s_done_e%0d", tag, e), if100.done, (e == 100));
            chk($sformatf("%s_active_e%0d", tag, e), if100.active, (e < 100));
        end
        if100.start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        if100.start = 1'b0;
        if2.start   = 1'b0;
        if1.start   = 1'b0;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0};

        // Reset asserted before any clock edge, then held with start toggling.
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_async_active", if100.active, 1'b0);
        chk("rst_async_done", if100.done, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if100.start = ~if100.start;
            if2.start   = ~if2.start;
            if1.start   = ~if1.start;
            step();
            chk("rst_hold_active100", if100.active, 1'b0);
            chk("rst_hold_done100", if100.done, 1'b0);
            chk("rst_hold_active2", if2.active, 1'b0);
            chk("rst_hold_done1", if1.done, 1'b0);
        end
        if100.start = 1'b0;
        if2.start   = 1'b0;
        if1.start   = 1'b0;
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_active", if100.active, 1'b0);
            chk("post_rst_done", if100.done, 1'b0);
        end

        // N_CLKS = 2 and 1 driven from the vector table.
        for (int i = 0; i < 8; i++) begin
            if2.start = vecs[i].start;
            if1.start = vecs[i].start;
            step();
            chk($sformatf("vec%0d_active2", i), if2.active, vecs[i].act2);
            chk($sformatf("vec%0d_done2", i), if2.done, vecs[i].done2);
            chk($sformatf("vec%0d_done1", i), if1.done, vecs[i].done1);
            chk($sformatf("vec%0d_active1", i), if1.active, 1'b0);
        end
        if2.start = 1'b0;
        if1.start = 1'b0;
        step();

        run_delay(0, 0, "single");
        run_delay(20, 50, "ignored");

        // Abort mid-delay: reset between edges #39 and #40.
        if100.start = 1'b1;
        step();
        if100.start = 1'b0;
        repeat (38) step();
        chk("abort_pre_active", if100.active, 1'b1);
        rst = 1'b0;
        #1;
        chk("abort_active", if100.active, 1'b0);
        chk("abort_done", if100.done, 1'b0);
        #2 rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            chk($sformatf("abort_nodone_%0d", i), if100.done, 1'b0);
            chk($sformatf("abort_noactive_%0d", i), if100.active, 1'b0);
        end
        run_delay(0, 0, "after_abort");

        // Start held high: back-to-back delays.
        if100.start = 1'b1;
        for (int e = 1; e <= 300; e++) begin
            step();
            chk($sformatf("b2b_done_e%0d", e), if100.done, (e % 100 == 0));
            chk($sformatf("b2b_active_e%0d", e), if100.active, (e % 100 != 0));
        end
        if100.start = 1'b0;
        step();
        chk("b2b_end_done", if100.done, 1'b0);
        chk("b2b_end_active", if100.active, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
